// File: rtl/add32_byte_serial.sv
// Byte-serial wide adder: one shared 8-bit carry-lookahead slice is stepped LSB
// first across latched operands, with carry chained through a register.

module cla_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       acc;
  logic       pp;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry expanded as a flat sum of generate terms, not rippled.
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    pp   = 1'b0;
    c[0] = ci;
    for (int i = 0; i < 8; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      acc      = acc | (pp & ci);
      c[i + 1] = acc;
    end
  end

  assign s  = p ^ c[7:0];
  assign co = c[8];

endmodule

module add32_byte_serial #(
  parameter int unsigned NUM_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_a,
  input  logic [8*NUM_BYTES-1:0] in_b,
  input  logic                   in_ci,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_s,
  output logic                   out_co,
  output logic                   out_ovf,
  output logic                   busy
);

  localparam int unsigned W     = 8 * NUM_BYTES;
  localparam int unsigned IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [7:0]       slice_s;
  logic             slice_co;
  logic             accept_c;
  logic             last_c;

  assign accept_c = (state == IDLE) && in_valid;
  assign last_c   = (idx == LAST_IDX);

  cla_8bit u_cla (
    .a  (a_q[8*idx +: 8]),
    .b  (b_q[8*idx +: 8]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // State register plus handshake flags decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      busy      <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = ADD;
      ADD:     if (last_c)    state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Operand capture and one byte of sum per cycle while in ADD.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      carry   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      out_s   <= '0;
      out_co  <= 1'b0;
      out_ovf <= 1'b0;
    end else if (accept_c) begin
      a_q   <= in_a;
      b_q   <= in_b;
      carry <= in_ci;
      idx   <= '0;
    end else if (state == ADD) begin
      out_s[8*idx +: 8] <= slice_s;
      carry             <= slice_co;
      if (last_c) begin
        out_co  <= slice_co;
        out_ovf <= (a_q[W-1] == b_q[W-1]) && (slice_s[7] != a_q[W-1]);
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_add32_byte_serial.sv
// Scoreboard bench for add32_byte_serial: expectations are queued at request
// time from a plain 33-bit reference sum and popped when out_valid appears.

module tb_add32_byte_serial;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_ci;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_s;
  logic        out_co;
  logic        out_ovf;
  logic        busy;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  add32_byte_serial #(.NUM_BYTES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ci     (in_ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_co    (out_co),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic ci);
    logic [32:0] full;
    exp_t e;
    full  = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    e.s   = full[31:0];
    e.co  = full[32];
    e.ovf = (a[31] == b[31]) && (full[31] != a[31]);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and pushes its expectation once the accept edge passes.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic ci);
    bit done = 0;
    in_a = a; in_b = b; in_ci = ci; in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) begin
        tick();
        done = 1;
      end else begin
        tick();
      end
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL issue_accept: in_ready never high for a=%h b=%h", a, b);
    end else begin
      sb.push_back(model(a, b, ci));
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_ci = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({out_valid, busy, in_ready, out_co, out_ovf} !== 5'b00100 || out_s !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: valid=%b busy=%b ready=%b s=%h co=%b ovf=%b want 0 0 1 0 0 0",
               out_valid, busy, in_ready, out_s, out_co, out_ovf);
    end
  endtask

  task automatic test_basic(input logic [31:0] a, input logic [31:0] b, input logic ci,
                            input string name, input bit check_lat);
    int   lat;
    exp_t e;
    issue(a, b, ci);
    wait_out(lat);
    if (check_lat) begin
      checks++;
      if (lat !== 4) begin
        failures++;
        $display("FAIL %s_latency: got %0d want 4", name, lat);
      end
    end
    checks++;
    if (!out_valid || sb.size() == 0) begin
      failures++;
      $display("FAIL %s_timeout: out_valid=%b queue=%0d", name, out_valid, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if (out_s !== e.s || out_co !== e.co || out_ovf !== e.ovf) begin
        failures++;
        $display("FAIL %s_result: s=%h co=%b ovf=%b want s=%h co=%b ovf=%b",
                 name, out_s, out_co, out_ovf, e.s, e.co, e.ovf);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_release: valid=%b ready=%b busy=%b want 0 1 0", name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    exp_t e;
    issue(32'h89ABCDEF, 32'h76543210, 1'b1);
    wait_out(lat);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      in_a = $urandom;
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_s !== e.s || out_co !== e.co || out_ovf !== e.ovf) begin
        failures++;
        $display("FAIL hold_%0d: valid=%b ready=%b s=%h co=%b ovf=%b want 1 0 s=%h co=%b ovf=%b",
                 i, out_valid, in_ready, out_s, out_co, out_ovf, e.s, e.co, e.ovf);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release: valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
    test_basic(32'h0000ABCD, 32'h00001234, 1'b0, "after_hold", 1'b1);
  endtask

  task automatic test_reset_abort();
    issue(32'hFFFF0000, 32'h0000FFFF, 1'b1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb.pop_back());
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_state: valid=%b ready=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL abort_ghost_%0d: out_valid=%b want 0", i, out_valid);
      end
    end
    test_basic(32'h12345678, 32'h11111111, 1'b0, "post_abort", 1'b1);
  endtask

  // out_ready held high throughout: DONE lasts one cycle, idle-time out_ready is inert.
  task automatic test_back_to_back();
    int   lat;
    exp_t e;
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      issue($urandom, $urandom, 1'($urandom_range(0, 1)));
      wait_out(lat);
      checks++;
      if (!out_valid || lat !== 4) begin
        failures++;
        $display("FAIL b2b_%0d_latency: valid=%b lat=%0d want 1 4", n, out_valid, lat);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (out_s !== e.s || out_co !== e.co || out_ovf !== e.ovf) begin
          failures++;
          $display("FAIL b2b_%0d_result: s=%h co=%b ovf=%b want s=%h co=%b ovf=%b",
                   n, out_s, out_co, out_ovf, e.s, e.co, e.ovf);
        end
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_%0d_release: valid=%b ready=%b want 0 1", n, out_valid, in_ready);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic(32'h000000FF, 32'h00000001, 1'b0, "byte_carry", 1'b1);
    test_basic(32'hFFFFFFFF, 32'h00000000, 1'b1, "full_chain", 1'b1);
    test_basic(32'h7FFFFFFF, 32'h00000001, 1'b0, "ovf_pos", 1'b0);
    test_basic(32'h80000000, 32'h80000000, 1'b0, "ovf_neg", 1'b0);
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
